// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C master arbiter: FSM states, command
// flag bundle layout and a constant-friendly clog2.
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_STOP_INJ  = 2'd3
  } arb_state_t;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  // Bit positions of the per-requester command flags inside one bundle
  localparam int CMD_START          = 0;
  localparam int CMD_READ           = 1;
  localparam int CMD_WRITE          = 2;
  localparam int CMD_WRITE_MULTIPLE = 3;
  localparam int CMD_STOP           = 4;
  localparam int CMD_FLAGS_W        = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin select: first asserted request at or after ptr,
// wrapping modulo N, returned as a one-hot winner plus a valid flag.
module i2c_rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             winner_valid
);

  logic [PTR_W:0] idx;

  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    idx          = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx >= (PTR_W + 1)'(N)) idx = idx - (PTR_W + 1)'(N);
      if (!winner_valid && req[idx[PTR_W-1:0]]) begin
        winner[idx[PTR_W-1:0]] = 1'b1;
        winner_valid           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arb.sv
// Shares one I2C master between NUM_REQ requesters, one whole transaction per grant.
// Optional idle-timeout stop injection is enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_master_arb
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [NUM_REQ*ADDR_W-1:0] s_cmd_address,
  input  logic [NUM_REQ-1:0]        s_cmd_start,
  input  logic [NUM_REQ-1:0]        s_cmd_read,
  input  logic [NUM_REQ-1:0]        s_cmd_write,
  input  logic [NUM_REQ-1:0]        s_cmd_write_multiple,
  input  logic [NUM_REQ-1:0]        s_cmd_stop,
  input  logic [NUM_REQ-1:0]        s_cmd_valid,
  output logic [NUM_REQ-1:0]        s_cmd_ready,

  input  logic [NUM_REQ*DATA_W-1:0] s_wr_tdata,
  input  logic [NUM_REQ-1:0]        s_wr_tvalid,
  input  logic [NUM_REQ-1:0]        s_wr_tlast,
  output logic [NUM_REQ-1:0]        s_wr_tready,

  output logic [DATA_W-1:0]         s_rd_tdata,
  output logic [NUM_REQ-1:0]        s_rd_tvalid,
  output logic [NUM_REQ-1:0]        s_rd_tlast,
  input  logic [NUM_REQ-1:0]        s_rd_tready,

  output logic [ADDR_W-1:0]         m_cmd_address,
  output logic                      m_cmd_start,
  output logic                      m_cmd_read,
  output logic                      m_cmd_write,
  output logic                      m_cmd_write_multiple,
  output logic                      m_cmd_stop,
  output logic                      m_cmd_valid,
  input  logic                      m_cmd_ready,

  output logic [DATA_W-1:0]         m_wr_tdata,
  output logic                      m_wr_tvalid,
  output logic                      m_wr_tlast,
  input  logic                      m_wr_tready,

  input  logic [DATA_W-1:0]         m_rd_tdata,
  input  logic                      m_rd_tvalid,
  input  logic                      m_rd_tlast,
  output logic                      m_rd_tready,

  input  logic                      m_busy,
`ifdef I2C_ARB_TIMEOUT_EN
  output logic [NUM_REQ-1:0]        timeout_flag,
`endif
  output logic [NUM_REQ-1:0]        grant,
  output logic                      grant_valid
);

  localparam int PTR_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("i2c_master_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_t state;
  logic [PTR_W-1:0] g_idx;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;

  logic [NUM_REQ-1:0] arb_winner;
  logic               arb_valid;
  logic [PTR_W-1:0]   winner_idx;

  logic [CMD_FLAGS_W-1:0] req_flags [NUM_REQ];
  logic [CMD_FLAGS_W-1:0] sel_flags;
  logic [ADDR_W-1:0]      sel_addr;
  logic                   sel_cmd_valid;
  logic                   sel_wr_tvalid;
  logic                   cmd_stop_hs;
  logic                   drain_done;

  i2c_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req          (s_cmd_valid),
    .ptr          (rr_ptr),
    .winner       (arb_winner),
    .winner_valid (arb_valid)
  );

  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_winner[i]) winner_idx = PTR_W'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_flags[i]                     = '0;
      req_flags[i][CMD_START]          = s_cmd_start[i];
      req_flags[i][CMD_READ]           = s_cmd_read[i];
      req_flags[i][CMD_WRITE]          = s_cmd_write[i];
      req_flags[i][CMD_WRITE_MULTIPLE] = s_cmd_write_multiple[i];
      req_flags[i][CMD_STOP]           = s_cmd_stop[i];
    end
  end

  assign sel_flags     = req_flags[g_idx];
  assign sel_addr      = s_cmd_address[int'(g_idx)*ADDR_W +: ADDR_W];
  assign sel_cmd_valid = s_cmd_valid[g_idx];
  assign sel_wr_tvalid = s_wr_tvalid[g_idx];
  assign cmd_stop_hs   = (state == ST_LOCKED) && sel_cmd_valid && m_cmd_ready && sel_flags[CMD_STOP];
  assign drain_done    = !m_busy && !m_rd_tvalid;
  assign next_ptr      = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
  assign s_rd_tdata    = m_rd_tdata;

  // Command path only opens in LOCKED; data streams stay routed until release
  // so read bytes still in flight after the stop reach the owner.
  always_comb begin
    m_cmd_address        = '0;
    m_cmd_start          = 1'b0;
    m_cmd_read           = 1'b0;
    m_cmd_write          = 1'b0;
    m_cmd_write_multiple = 1'b0;
    m_cmd_stop           = 1'b0;
    m_cmd_valid          = 1'b0;
    s_cmd_ready          = '0;
    m_wr_tdata           = '0;
    m_wr_tvalid          = 1'b0;
    m_wr_tlast           = 1'b0;
    s_wr_tready          = '0;
    s_rd_tvalid          = '0;
    s_rd_tlast           = '0;
    m_rd_tready          = 1'b0;
    if (state == ST_LOCKED) begin
      m_cmd_address        = sel_addr;
      m_cmd_start          = sel_flags[CMD_START];
      m_cmd_read           = sel_flags[CMD_READ];
      m_cmd_write          = sel_flags[CMD_WRITE];
      m_cmd_write_multiple = sel_flags[CMD_WRITE_MULTIPLE];
      m_cmd_stop           = sel_flags[CMD_STOP];
      m_cmd_valid          = sel_cmd_valid;
      s_cmd_ready[g_idx]   = m_cmd_ready;
    end
`ifdef I2C_ARB_TIMEOUT_EN
    if (state == ST_STOP_INJ) begin
      m_cmd_stop  = 1'b1;
      m_cmd_valid = 1'b1;
    end
`endif
    if (state != ST_IDLE) begin
      m_wr_tdata         = s_wr_tdata[int'(g_idx)*DATA_W +: DATA_W];
      m_wr_tvalid        = sel_wr_tvalid;
      m_wr_tlast         = s_wr_tlast[g_idx];
      s_wr_tready[g_idx] = m_wr_tready;
      s_rd_tvalid[g_idx] = m_rd_tvalid;
      s_rd_tlast[g_idx]  = m_rd_tlast;
      m_rd_tready        = s_rd_tready[g_idx];
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             lock_idle;
  assign lock_idle = !sel_cmd_valid && !sel_wr_tvalid && !m_busy;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      g_idx       <= '0;
      rr_ptr      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      idle_cnt     <= '0;
      timeout_flag <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            grant       <= arb_winner;
            g_idx       <= winner_idx;
            grant_valid <= 1'b1;
            state       <= ST_LOCKED;
`ifdef I2C_ARB_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
          end
        end
        ST_LOCKED: begin
          if (cmd_stop_hs) begin
            state <= ST_WAIT_BUSY;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (lock_idle) begin
            if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
              state    <= ST_STOP_INJ;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
`endif
        end
        ST_WAIT_BUSY: begin
          if (drain_done) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= ST_IDLE;
          end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        ST_STOP_INJ: begin
          if (m_cmd_ready) begin
            timeout_flag[g_idx] <= 1'b1;
            state               <= ST_WAIT_BUSY;
          end
        end
`endif
        default: begin
          grant       <= '0;
          grant_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_master_arb.md
Name: i2c_master_arb

Overview:
- Shares one I2C master command/data interface between NUM_REQ requesters, e.g. a housekeeping sequencer and a host bridge.
- Grants the master to one requester for a whole bus transaction, from the first command up to and including the command carrying stop.
- Round-robin between transactions.
- Routes the granted requester's write-data stream to the master and the master's read-data stream back to that requester only.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 1024, idle cycles in a locked grant before forced release (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- s_cmd_address  in  NUM_REQ*7  per-requester 7-bit target address, requester i at [7i+6:7i]
- s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple, s_cmd_stop  in  NUM_REQ each  per-requester command flags
- s_cmd_valid  in  NUM_REQ  command valid
- s_cmd_ready  out  NUM_REQ  command ready
- s_wr_tdata  in  NUM_REQ*8  write data
- s_wr_tvalid, s_wr_tlast  in  NUM_REQ  write stream valid/last
- s_wr_tready  out  NUM_REQ  write stream ready
- s_rd_tdata  out  8  read data, broadcast to all requesters
- s_rd_tvalid, s_rd_tlast  out  NUM_REQ  read stream valid/last, granted requester only
- s_rd_tready  in  NUM_REQ  read stream ready
- m_cmd_address  out  7  to master
- m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid  out  1  to master
- m_cmd_ready  in  1  from master
- m_wr_tdata  out  8  to master
- m_wr_tvalid, m_wr_tlast  out  1  to master
- m_wr_tready  in  1  from master
- m_rd_tdata  in  8  from master
- m_rd_tvalid, m_rd_tlast  in  1  from master
- m_rd_tready  out  1  to master
- m_busy  in  1  master bus activity
- grant  out  NUM_REQ  one-hot current owner
- grant_valid  out  1  a grant is held

Behaviour:
- Reset (rst low, async): state IDLE, grant=0, grant_valid=0, rr pointer=0. All m_*_valid, s_*_ready, s_rd_tvalid and m_rd_tready are 0.
- IDLE:
  - When any s_cmd_valid is high, pick the first asserted index at or after rr pointer, wrapping modulo NUM_REQ.
  - Register grant; go to LOCKED next cycle. Arbitration latency is 1 cycle; no command passes during the arbitration cycle.
- LOCKED:
  - Combinational passthrough for the granted index: m_cmd_* = s_cmd_*[g], s_cmd_ready[g] = m_cmd_ready, likewise for the wr stream.
  - Read stream: s_rd_tvalid[g] = m_rd_tvalid, m_rd_tready = s_rd_tready[g].
  - Ungranted requesters see ready=0 and rd_tvalid=0.
  - A command handshake (valid&ready) with s_cmd_stop[g]=1 goes to WAIT_BUSY.
- WAIT_BUSY:
  - Command path blocked (m_cmd_valid=0); wr/rd streams stay routed to g so trailing read data drains.
  - When m_busy=0 and m_rd_tvalid=0: grant cleared, rr pointer = g+1 mod NUM_REQ, go to IDLE.
- Requests raised during a grant wait; no preemption.
- Simultaneous requests in IDLE: the lowest index at or after the rr pointer wins. A single requester may win back-to-back if it is alone.
- A requester dropping s_cmd_valid while LOCKED keeps its grant; only stop (or timeout) releases it.
- Master errors are not interpreted; the requester owns recovery.

Optional Feature:
- I2C_ARB_TIMEOUT_EN defined:
  - A counter (clog2(TIMEOUT+1) bits) counts LOCKED cycles with s_cmd_valid[g]=0, s_wr_tvalid[g]=0 and m_busy=0. Any of these being active clears it.
  - On reaching TIMEOUT, go to STOP_INJ: drive m_cmd_stop=1, m_cmd_valid=1, other flags 0, address 0; s_cmd_ready[g]=0.
  - After m_cmd_ready, go to WAIT_BUSY. Pulse sticky status timeout_flag[g] (extra output port, NUM_REQ wide, cleared by reset only).
- Undefined: no counter, no STOP_INJ state, no timeout_flag port; a grant is held indefinitely.

Decomposition:
- Package i2c_arb_pkg: state encoding (IDLE, LOCKED, WAIT_BUSY, STOP_INJ), command flag bundle field offsets, clog2 function.
- Sub-module i2c_rr_arbiter: combinational round-robin priority select, taking request vector and pointer and returning a one-hot winner plus valid. Reused elsewhere.

Test Plan:
- Single requester 0 issues start+write addr 0x70 data 0x5A with stop → forwarded unchanged; grant=01 for the whole transaction; released after m_busy falls; rr pointer=1.
- Requesters 0 and 1 assert in the same cycle, pointer=0 → 0 wins. After its stop, 1 wins with no idle gap beyond arbitration plus the WAIT_BUSY drain.
- Requester 1 requests mid-transaction of 0 → s_cmd_ready[1] stays 0 until 0's stop handshake and m_busy=0.
- Read of 2 bytes (0x11, 0x22) by requester 1 → s_rd_tvalid[1] only; s_rd_tvalid[0] stays 0; backpressure on s_rd_tready[1] stalls m_rd_tready.
- rst low mid-LOCKED → all valid/ready/grant 0 immediately (async); IDLE after release.
- I2C_ARB_TIMEOUT_EN, TIMEOUT=16: grantee goes silent after start → stop injected at cycle 16, timeout_flag[g]=1, grant released.
